// File: rtl/filter_bank_readout.sv
// filter_bank_readout
//   Snapshots all filter-bank band values on an eligible sample strobe and
//   streams them out one band per beat over valid/ready, with first/last
//   frame markers. Eligible strobes that arrive while a frame is still being
//   sent are dropped and raise a sticky overrun flag.
//
// Ports
//   clk, reset        : single clock, synchronous active-high reset
//   i_sample_strobe   : one-cycle pulse, i_bands valid this cycle
//   i_bands           : TOTAL_FILTERS packed band values, band 0 in the LSBs
//   o_data / o_index  : current band value and its band number
//   o_valid / i_ready : beat handshake
//   o_first / o_last  : markers on band 0 and band TOTAL_FILTERS-1
//   o_busy            : a frame is held
//   o_overrun         : sticky drop flag, cleared by i_clear_overrun
//
// States
//   S_IDLE | no frame held, waiting for an eligible strobe
//   S_SEND | snapshot held, offering beat o_index
module filter_bank_readout #(
  parameter int BITS_PER_ELEM = 8,
  parameter int TOTAL_FILTERS = 8,
  parameter int BAND_BITS     = 16,
  parameter int DECIMATE      = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               i_sample_strobe,
  input  logic [TOTAL_FILTERS*BAND_BITS-1:0] i_bands,
  output logic [BAND_BITS-1:0]               o_data,
  output logic [$clog2(TOTAL_FILTERS)-1:0]   o_index,
  output logic                               o_valid,
  input  logic                               i_ready,
  output logic                               o_first,
  output logic                               o_last,
  output logic                               o_busy,
  output logic                               o_overrun,
  input  logic                               i_clear_overrun
);

  localparam int IW = $clog2(TOTAL_FILTERS);
  localparam int DW = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [IW-1:0] IDX_PENULT = IW'(TOTAL_FILTERS - 2);
  localparam logic [DW-1:0] DCNT_MAX   = DW'(DECIMATE - 1);

  // BITS_PER_ELEM only documents the upstream tap width.
  if (TOTAL_FILTERS < 2 || DECIMATE < 1 || BITS_PER_ELEM < 1) begin : g_bad_params
    $error("filter_bank_readout: illegal parameter set");
  end

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                state;
  logic [DW-1:0]         dcnt;
  logic [BAND_BITS-1:0]  snap [TOTAL_FILTERS];
  logic                  eligible;
  logic                  last_accept;
  logic                  start_frame;
  logic                  drop;
  logic [IW-1:0]         idx_next;

  assign eligible    = i_sample_strobe && (dcnt == '0);
  assign last_accept = (state == S_SEND) && i_ready && o_last;
  // A strobe aligned with the final accepted beat chains straight into a new
  // frame; any other eligible strobe during SEND is a drop.
  assign start_frame = eligible && ((state == S_IDLE) || last_accept);
  assign drop        = eligible && (state == S_SEND) && !last_accept;
  assign idx_next    = o_index + 1'b1;

  assign o_valid = (state == S_SEND);
  assign o_busy  = (state == S_SEND);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      dcnt      <= '0;
      o_index   <= '0;
      o_data    <= '0;
      o_first   <= 1'b0;
      o_last    <= 1'b0;
      o_overrun <= 1'b0;
      for (int k = 0; k < TOTAL_FILTERS; k++) snap[k] <= '0;
    end else begin
      if (i_sample_strobe)
        dcnt <= (dcnt == DCNT_MAX) ? '0 : dcnt + 1'b1;

      // Set is written after clear so a same-cycle drop wins.
      if (i_clear_overrun) o_overrun <= 1'b0;
      if (drop)            o_overrun <= 1'b1;

      if (start_frame) begin
        for (int k = 0; k < TOTAL_FILTERS; k++)
          snap[k] <= i_bands[k*BAND_BITS +: BAND_BITS];
        state   <= S_SEND;
        o_index <= '0;
        o_data  <= i_bands[BAND_BITS-1:0];
        o_first <= 1'b1;
        o_last  <= 1'b0;
      end else if (state == S_SEND && i_ready) begin
        if (o_last) begin
          state   <= S_IDLE;
          o_first <= 1'b0;
          o_last  <= 1'b0;
        end else begin
          o_index <= idx_next;
          o_data  <= snap[idx_next];
          o_first <= 1'b0;
          o_last  <= (o_index == IDX_PENULT);
        end
      end
    end
  end

endmodule

// File: doc/filter_bank_readout.md
# filter_bank_readout

Streams the per-band outputs of the wavelet filter bank out of the chip, one band per transfer. On an eligible sample strobe it snapshots all `TOTAL_FILTERS` band values, then transmits them in order over a valid/ready interface with frame markers. It sits downstream of the filter bank and is the reader for the values the bank writes. Frames arriving while a frame is still being sent are dropped and flagged.

## Interface
**Parameters**
- `BITS_PER_ELEM`, 8: tap width of the filter bank. Documentation only; not used in logic.
- `TOTAL_FILTERS`, 8: number of bands per frame. Must be ≥ 2.
- `BAND_BITS`, 16: width of one band value.
- `DECIMATE`, 1: capture one strobe in every `DECIMATE`. Must be ≥ 1.

**Ports**
- `clk`, input, 1: single clock. All logic is on its rising edge.
- `reset`, input, 1: synchronous, active-high reset.
- `i_sample_strobe`, input, 1: one-cycle pulse meaning `i_bands` is valid this cycle.
- `i_bands`, input, `TOTAL_FILTERS*BAND_BITS`: band k is `i_bands[k*BAND_BITS +: BAND_BITS]`. Band 0 is the highest-frequency filter.
- `o_data`, output, `BAND_BITS`: the current band value.
- `o_index`, output, `$clog2(TOTAL_FILTERS)`: the band number of `o_data`.
- `o_valid`, output, 1: a beat is offered.
- `i_ready`, input, 1: the sink accepts the beat.
- `o_first`, output, 1: high with the band 0 beat.
- `o_last`, output, 1: high with the band `TOTAL_FILTERS-1` beat.
- `o_busy`, output, 1: high while a frame is held (equals the SEND state).
- `o_overrun`, output, 1: sticky flag, set when an eligible strobe is dropped.
- `i_clear_overrun`, input, 1: clears `o_overrun`.

## Operation
- **Reset values.** While `reset` is high at an edge, every output goes to 0: `o_valid`, `o_first`, `o_last`, `o_busy`, `o_overrun`, `o_index`, `o_data`. The decimation counter and snapshot register also go to 0. Reset mid-frame abandons the frame with no further beats.
- **Decimation counter `dcnt`.** Range 0..DECIMATE-1.
  - It advances on every `i_sample_strobe`, whether the strobe is captured or dropped, and wraps from DECIMATE-1 to 0.
  - A strobe is *eligible* when `dcnt == 0` at that strobe.
  - With `DECIMATE = 1`, every strobe is eligible.
- **State machine: two states, IDLE and SEND.**
  - IDLE → SEND on an eligible strobe. `i_bands` is copied into the snapshot and `o_index` is set to 0.
  - SEND: `o_valid = 1` and `o_data = snapshot[o_index]`.
    - `o_first = (o_index == 0)`.
    - `o_last = (o_index == TOTAL_FILTERS-1)`.
  - SEND, handshake (`o_valid && i_ready`) with `o_last = 0`: `o_index` increments.
  - SEND, handshake with `o_last = 1`:
    - With an eligible strobe in the same cycle: take a new snapshot, set `o_index` to 0, stay in SEND. This is not an overrun.
    - Otherwise, go to IDLE.
  - SEND, eligible strobe in any other cycle: the strobe is dropped, `o_overrun` is set, and the snapshot is unchanged.
- **Beat stability.** While `o_valid && !i_ready`, `o_data`, `o_index`, `o_first` and `o_last` hold their values.
- **Overrun clear.** `i_clear_overrun` clears `o_overrun` at the next edge. If a set and a clear happen in the same cycle, the set wins.
- **Strobe during reset.** A strobe in a reset cycle is ignored and does not advance `dcnt`.
- **Widths.** No arithmetic is applied to band data; it is copied bit-exact. `o_index` never exceeds TOTAL_FILTERS-1.

## Timing
- An eligible strobe at edge N (state IDLE) gives `o_valid = 1`, `o_index = 0` and `o_first = 1` after edge N.
- With `i_ready` held high, one beat transfers per cycle. A frame takes exactly `TOTAL_FILTERS` cycles.
- With `i_ready` held high and back-to-back eligible strobes every `TOTAL_FILTERS` cycles, aligned to the last beat, `o_valid` stays high with no gap.
- After the last beat is accepted with no new strobe, `o_valid = 0` from the next cycle.
- `o_busy` equals `o_valid`.
- All outputs are registered. There is no combinational path from `i_ready` to `o_valid`.

## Test plan
1. **Basic frame.** Reset, then `TOTAL_FILTERS=8`, `i_bands` = band k holds 16'h1000+k, strobe once, `i_ready = 1`.
   - Expect 8 consecutive beats with data 0x1000..0x1007 and index 0..7.
   - `o_first` is high only on beat 0; `o_last` is high only on beat 7.
   - `o_valid` is 0 afterwards.
2. **Backpressure.** As scenario 1, but `i_ready` toggles 1,0,0,1,…
   - Expect data and index to hold during the stall cycles.
   - All 8 values arrive in order with no duplicates and no drops.
3. **Overrun.** Strobe, then strobe again at beat index 3 with new data 16'hBEEF.
   - Expect the first frame to complete unaltered.
   - `o_overrun` is 1 from the next cycle and stays 1.
   - After `i_clear_overrun` pulses, `o_overrun` is 0.
   - A clear pulsed in the same cycle as a new drop leaves `o_overrun` at 1.
4. **Seamless chain.** A second strobe lands in the cycle the last beat is accepted.
   - Expect no overrun and `o_valid` continuously high.
   - The next beat is index 0 carrying the second snapshot.
5. **Decimation.** `DECIMATE=3`, 7 strobes spaced 10 cycles apart, `i_ready = 1`.
   - Expect frames only for strobes 1, 4 and 7.
   - Strobes 2, 3, 5 and 6 produce no overrun.
6. **Reset mid-frame.** Assert `reset` at beat index 5 for one cycle.
   - Expect all outputs to be 0 the next cycle and no further beats.
   - The next strobe starts a fresh frame at index 0, and `dcnt` has restarted from 0.
